// File: rtl/branch_resolution_queue_pkg.sv
// Shared types for the branch resolution queue: the machine data word and
// one in-flight prediction record, plus the sequential fall-through PC helper.
// Pure declarations; no logic, no latency, no flow control.
package branch_resolution_queue_pkg;

  typedef logic [31:0] data_word_t;

  typedef struct packed {
    data_word_t pc;
    logic       taken;
    data_word_t target;
  } prediction_entry_t;

  // Address of the next sequential instruction; wraps modulo 2^32.
  function automatic data_word_t fallthrough_pc(input data_word_t pc,
                                                input logic compressed);
    return pc + (compressed ? 32'd2 : 32'd4);
  endfunction

endpackage

// File: rtl/branch_resolution_queue_prediction_fifo.sv
// Circular buffer of predictions in program order, head read combinationally.
// Latency: a push is visible at the head one cycle later; pop takes effect next cycle.
// Backpressure: push dropped when full unless a pop happens in the same cycle; pop ignored when empty.
module prediction_fifo
  import branch_resolution_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  prediction_entry_t push_data,
  input  logic              pop,
  output prediction_entry_t head,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  prediction_entry_t mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              do_pop;
  logic              do_push;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth; clear drops every entry.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_resolution_queue.sv
// Holds fetch predictions until execute resolves them; flags redirects and feeds the BTB.
// Latency: mispredict, redirect PC, error and BTB update are registered, valid 1 cycle after resolve.
// Backpressure: full_o drops lone pushes; push with a same-cycle resolve is accepted even when full.
module branch_resolution_queue
  import branch_resolution_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [31:0] push_pc_i,
  input  logic        push_taken_i,
  input  logic [31:0] push_target_i,
  output logic        full_o,
  output logic        empty_o,
  input  logic        resolve_i,
  input  logic        resolve_taken_i,
  input  logic [31:0] resolve_target_i,
  input  logic        resolve_branch_i,
  input  logic        resolve_jump_i,
  input  logic        resolve_compressed_i,
  output logic        mispredict_o,
  output logic [31:0] correct_pc_o,
  output logic        resolve_error_o,
  output logic [31:0] btb_instr_address_o,
  output logic [31:0] btb_target_o,
  output logic        btb_taken_o,
  output logic        btb_branch_o,
  output logic        btb_jump_o
);

  prediction_entry_t head;
  prediction_entry_t push_entry;
  logic              resolve_valid;
  logic              mispredict;
  logic              fifo_clear;
  logic              fifo_push;
  logic              fifo_pop;
  data_word_t        redirect_pc;

  assign push_entry = '{pc: push_pc_i, taken: push_taken_i, target: push_target_i};

  assign resolve_valid = resolve_i & ~empty_o;

  // Wrong direction, or right direction (taken) but wrong destination.
  assign mispredict = resolve_valid &
                      ((head.taken != resolve_taken_i) |
                       (head.taken & resolve_taken_i & (head.target != resolve_target_i)));

  assign redirect_pc = resolve_taken_i ? resolve_target_i
                                       : fallthrough_pc(head.pc, resolve_compressed_i);

  // Everything younger than a mispredicted entry is wrong-path, including a same-cycle push.
  assign fifo_clear = flush_i | mispredict;
  assign fifo_push  = push_i & ~fifo_clear;
  assign fifo_pop   = resolve_valid & ~flush_i;

  prediction_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head),
    .full      (full_o),
    .empty     (empty_o)
  );

  // Redirect, error pulse and BTB update registers; flush zeroes all of them.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      mispredict_o        <= 1'b0;
      correct_pc_o        <= '0;
      resolve_error_o     <= 1'b0;
      btb_instr_address_o <= '0;
      btb_target_o        <= '0;
      btb_taken_o         <= 1'b0;
      btb_branch_o        <= 1'b0;
      btb_jump_o          <= 1'b0;
    end else begin
      mispredict_o    <= mispredict;
      resolve_error_o <= resolve_i & empty_o;
      if (mispredict) correct_pc_o <= redirect_pc;
      if (resolve_valid) begin
        btb_instr_address_o <= head.pc;
        btb_target_o        <= resolve_target_i;
      end
      btb_taken_o  <= resolve_valid & resolve_taken_i;
      btb_branch_o <= resolve_valid & resolve_branch_i;
      btb_jump_o   <= resolve_valid & resolve_jump_i;
    end
  end

endmodule
